// File: rtl/cpu_out_uart_tx_pkg.sv
// Shared types and constants for the CPU output-port UART logger.
// The PARITY state is only reachable when CPU_OUT_UART_PARITY_EN is defined.
package cpu_out_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  localparam int   DEF_CLKS_PER_BIT = 16;
  localparam int   DEF_FIFO_DEPTH   = 4;
  localparam logic UART_IDLE        = 1'b1;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cpu_out_uart_tx_fifo.sv
// Small circular byte FIFO; head is presented combinationally, push and pop
// in the same cycle are both honoured even when full.
module cpu_out_uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [7:0]                   i_din,
  output logic [7:0]                   o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd];
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign o_drop    = i_push && o_full && !i_pop;

  // storage array; stale entries are ignored once pointers are reset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/cpu_out_uart_tx.sv
// Logs every change of the CPU output byte as an 8N1 UART frame on one pin.
// Define CPU_OUT_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module cpu_out_uart_tx
  import cpu_out_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [7:0]                        data_in,
  input  logic                              clear_ovf,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);
  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  tx_state_e  r_state;
  logic       r_tx;
  logic       r_busy;
  logic       r_ovf;
  logic [7:0] r_prev;
  logic [7:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
`ifdef CPU_OUT_UART_PARITY_EN
  logic       r_par;
`endif

  logic       w_enq;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_drop;
  logic       w_ovf_set;
  logic       w_baud_end;
  logic [7:0] w_head;

  assign w_enq      = (data_in != r_prev);
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_baud_end = (r_baud == BAUD_MAX);
  // a drop can only occur while full; qualifying on both keeps the set path explicit
  assign w_ovf_set  = w_drop && w_full;

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_ovf;

  cpu_out_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_din   (data_in),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count),
    .o_drop  (w_drop)
  );

  // change detector history and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 8'h00;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= data_in;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // transmit state machine; the shift register keeps the current bit in [0]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tx    <= UART_IDLE;
      r_busy  <= 1'b0;
      r_baud  <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
`ifdef CPU_OUT_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_baud  <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
`ifdef CPU_OUT_UART_PARITY_EN
            r_par   <= even_parity(w_head);
`endif
          end else begin
            r_tx   <= UART_IDLE;
            r_busy <= 1'b0;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_baud  <= 8'd0;
            r_tx    <= r_shift[0];
            r_bit   <= 3'd0;
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            r_baud <= 8'd0;
            if (r_bit == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
              r_tx    <= r_par;
              r_state <= ST_PARITY;
`else
              r_tx    <= UART_IDLE;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
`ifdef CPU_OUT_UART_PARITY_EN
        ST_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= 8'd0;
            r_tx    <= UART_IDLE;
            r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
`endif
        ST_STOP: begin
          if (w_baud_end) begin
            r_baud  <= 8'd0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        default: begin
          r_tx    <= UART_IDLE;
          r_busy  <= 1'b0;
          r_baud  <= 8'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Scoreboard bench: a queue-based model predicts every frame (byte and start
// cycle); a separate monitor decodes tx and checks against the queue.
module tb_cpu_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CPU_OUT_UART_PARITY_EN
  localparam int NCELL = 11;
`else
  localparam int NCELL = 10;
`endif
  localparam int FRAME = NCELL * CPB;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       clear_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;

  logic [7:0]  m_q[$];
  exp_t        exp_q[$];
  logic [7:0]  m_prev = 8'h00;
  logic        m_ovf = 1'b0;
  int unsigned m_next_pop = 0;

  cpu_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .clear_ovf  (clear_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge: drive inputs, advance the reference model, check status outputs.
  task automatic cycle(input logic [7:0] d, input logic clr);
    logic enq;
    logic deq;
    logic drop;
    data_in   = d;
    clear_ovf = clr;
    @(posedge clk);
    cyc++;
    deq  = (m_q.size() != 0) && (cyc >= m_next_pop);
    enq  = (d != m_prev);
    drop = enq && !deq && (m_q.size() >= DEPTH);
    if (deq) begin
      exp_q.push_back('{cyc, m_q.pop_front()});
      m_next_pop = cyc + FRAME + 1;
    end
    if (enq && !drop) m_q.push_back(d);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = d;
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    clear_ovf = 1'b0;
  endtask

  task automatic hold(input int n);
    logic [7:0] d;
    d = data_in;
    repeat (n) cycle(d, 1'b0);
  endtask

  task automatic do_reset();
    data_in   = 8'h00;
    clear_ovf = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    m_q.delete();
    exp_q.delete();
    m_prev     = 8'h00;
    m_ovf      = 1'b0;
    m_next_pop = 0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1 reset_n = 1'b1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int s);
    int c;
    c = s / CPB;
    if (c == 0) return 1'b0;
    if (c <= 8) return d[c-1];
`ifdef CPU_OUT_UART_PARITY_EN
    if (c == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Monitor: decode frames on tx and compare with the scoreboard queue.
  initial begin
    bit         in_frame;
    int         s;
    int         bad;
    logic [7:0] got;
    exp_t       e;
    in_frame = 1'b0;
    s = 0;
    bad = 0;
    got = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("spurious_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_start_cycle", cyc, e.cyc);
            in_frame = 1'b1;
            s = 0;
            bad = 0;
            got = 8'h00;
          end
        end
        if (in_frame) begin
          if (tx !== exp_bit(e.data, s) || busy !== 1'b1) bad++;
          if ((s % CPB) == CPB / 2 && s / CPB >= 1 && s / CPB <= 8) got[s/CPB-1] = tx;
          s++;
          if (s == FRAME) begin
            chk("frame_byte", 32'(got), 32'(e.data));
            chk("frame_bad_samples", 32'(bad), 32'd0);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    do_reset();

    // idle after reset
    for (int i = 0; i < 100; i++) begin
      cycle(8'h00, 1'b0);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // single byte with one-edge latency
    cycle(8'hA5, 1'b0);
    chk("lat_e0_tx", 32'(tx), 32'd1);
    cycle(8'hA5, 1'b0);
    chk("lat_e1_tx", 32'(tx), 32'd0);
    hold(FRAME + 10);
    chk("single_drained", 32'(exp_q.size()), 32'd0);

    // repeated identical value sends one frame
    cycle(8'h11, 1'b0);
    cycle(8'h11, 1'b0);
    cycle(8'h11, 1'b0);
    hold(FRAME * 2);
    chk("norepeat_drained", 32'(exp_q.size()), 32'd0);

    // back-to-back bursts and overflow
    cycle(8'h00, 1'b0);
    hold(FRAME + 5);
    for (int i = 1; i <= 6; i++) cycle(8'(i), 1'b0);
    chk("burst_count", 32'(fifo_count), 32'd4);
    chk("burst_ovf", 32'(overflow), 32'd1);
    hold(5 * (FRAME + 1) + 10);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);
    cycle(8'h06, 1'b1);
    chk("clear_ovf", 32'(overflow), 32'd0);

    // parity-sensitive bytes
    cycle(8'h07, 1'b0);
    hold(FRAME + 5);
    cycle(8'h03, 1'b0);
    hold(FRAME + 5);

    // reset during data bit 3 of 0x5A
    cycle(8'h5A, 1'b0);
    hold(17);
    do_reset();
    hold(FRAME * 2);
    chk("post_reset_count", 32'(fifo_count), 32'd0);
    chk("post_reset_tx", 32'(tx), 32'd1);

    // randomized traffic with occasional repeats and overflow clears
    for (int seg = 0; seg < 80; seg++) begin
      d = ($urandom_range(0, 3) == 0) ? data_in : 8'($urandom_range(0, 255));
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        cycle(d, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
    end
    hold((DEPTH + 2) * (FRAME + 1));
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
